// File: rtl/priority_encoder_rr.sv
// Registered request encoder with fixed or round-robin arbitration. The winning
// index and its one-hot grant are held on a valid/ready handshake until accepted.
module priority_encoder_rr #(
  parameter int WIDTH = 8,
  parameter bit RR_EN = 1'b1,
  localparam int POS_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] req_in,
  input  logic             mode,
  output logic             enc_valid,
  input  logic             enc_ready,
  output logic [POS_W-1:0] pos,
  output logic [WIDTH-1:0] onehot,
  output logic [POS_W-1:0] ptr_dbg
);

  // state  | meaning
  // IDLE   | no result held, waiting for any request
  // HOLD   | result valid on pos/onehot until enc_ready
  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t           state_q;
  logic             valid_q;
  logic             mode_q;
  logic [POS_W-1:0] pos_q;
  logic [WIDTH-1:0] onehot_q;
  logic [POS_W-1:0] ptr_q;

  logic             accept;
  logic             rr_sel;
  logic [POS_W-1:0] ptr_d;
  logic [POS_W:0]   srch;
  logic             found;
  logic [POS_W-1:0] win;

  // Returns {found, index} of the first set bit at or after start, wrapping at WIDTH-1.
  function automatic logic [POS_W:0] search(input logic [WIDTH-1:0] req, input int start);
    logic [POS_W:0]   r;
    logic [POS_W-1:0] ip;
    int               idx;
    r = '0;
    for (int k = WIDTH - 1; k >= 0; k--) begin
      idx = start + k;
      if (idx >= WIDTH) idx = idx - WIDTH;
      ip = POS_W'(idx);
      if (req[ip]) r = {1'b1, ip};
    end
    return r;
  endfunction

  always_comb begin
    accept = valid_q & enc_ready;
    rr_sel = RR_EN && mode;
    ptr_d  = ptr_q;
    // Only an accepted round-robin result advances the pointer; fixed results leave it parked.
    if (accept && mode_q)
      ptr_d = (pos_q == POS_W'(WIDTH - 1)) ? '0 : pos_q + 1'b1;
    srch  = search(req_in, rr_sel ? int'(ptr_d) : 0);
    found = srch[POS_W];
    win   = srch[POS_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      valid_q  <= 1'b0;
      mode_q   <= 1'b0;
      pos_q    <= '0;
      onehot_q <= '0;
      ptr_q    <= '0;
    end else begin
      ptr_q <= ptr_d;
      case (state_q)
        S_IDLE: begin
          if (found) begin
            state_q  <= S_HOLD;
            valid_q  <= 1'b1;
            mode_q   <= rr_sel;
            pos_q    <= win;
            onehot_q <= WIDTH'(1) << win;
          end
        end
        S_HOLD: begin
          if (enc_ready) begin
            if (found) begin
              mode_q   <= rr_sel;
              pos_q    <= win;
              onehot_q <= WIDTH'(1) << win;
            end else begin
              state_q <= S_IDLE;
              valid_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= S_IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign enc_valid = valid_q;
  assign pos       = pos_q;
  assign onehot    = onehot_q;
  assign ptr_dbg   = ptr_q;

endmodule

// File: tb/tb_priority_encoder_rr.sv
// Bench for priority_encoder_rr: an 8-wide and a 5-wide instance driven from a
// vector table through an expectation queue, plus a mid-HOLD reset sequence.
module tb_priority_encoder_rr;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req8;
  logic       mode8, rdy8;
  logic       v8;
  logic [2:0] pos8, ptr8;
  logic [7:0] oh8;
  logic [4:0] req5;
  logic       mode5, rdy5;
  logic       v5;
  logic [2:0] pos5, ptr5;
  logic [4:0] oh5;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  priority_encoder_rr #(.WIDTH(8), .RR_EN(1'b1)) u8 (
    .clk(clk), .rst(rst), .req_in(req8), .mode(mode8), .enc_valid(v8),
    .enc_ready(rdy8), .pos(pos8), .onehot(oh8), .ptr_dbg(ptr8));

  priority_encoder_rr #(.WIDTH(5), .RR_EN(1'b1)) u5 (
    .clk(clk), .rst(rst), .req_in(req5), .mode(mode5), .enc_valid(v5),
    .enc_ready(rdy5), .pos(pos5), .onehot(oh5), .ptr_dbg(ptr5));

  typedef struct {
    logic       w5;
    logic [7:0] req;
    logic       mode;
    logic       rdy;
    logic       ev;
    logic [2:0] epos;
    logic [2:0] eptr;
  } vec_t;

  vec_t tbl[$];
  vec_t exp_q[$];

  task automatic check(input string nm, input int step, input logic [31:0] act, input logic [31:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s step %0d: got %0h expected %0h", nm, step, act, expv);
  endtask

  task automatic add(input logic w5, input logic [7:0] req, input logic mode, input logic rdy,
                     input logic ev, input logic [2:0] epos, input logic [2:0] eptr);
    vec_t v;
    v.w5 = w5; v.req = req; v.mode = mode; v.rdy = rdy;
    v.ev = ev; v.epos = epos; v.eptr = eptr;
    tbl.push_back(v);
  endtask

  task automatic drive(input vec_t v);
    if (v.w5) begin
      req5 = v.req[4:0]; mode5 = v.mode; rdy5 = v.rdy;
      req8 = '0; mode8 = 1'b0; rdy8 = 1'b0;
    end else begin
      req8 = v.req; mode8 = v.mode; rdy8 = v.rdy;
      req5 = '0; mode5 = 1'b0; rdy5 = 1'b0;
    end
  endtask

  initial begin
    vec_t e;
    logic [7:0] oh_exp;

    rst = 1'b0; req8 = '0; req5 = '0; mode8 = 1'b0; mode5 = 1'b0; rdy8 = 1'b0; rdy5 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid8", 0, 32'(v8), 0);
    check("rst_pos8", 0, 32'(pos8), 0);
    check("rst_onehot8", 0, 32'(oh8), 0);
    check("rst_ptr8", 0, 32'(ptr8), 0);
    check("rst_valid5", 0, 32'(v5), 0);
    rst = 1'b1;

    // fixed priority, A4 held with ready: pos 2 every cycle, ptr parked
    add(0, 8'hA4, 0, 1, 1, 2, 0);
    add(0, 8'hA4, 0, 1, 1, 2, 0);
    add(0, 8'hA4, 0, 1, 1, 2, 0);
    add(0, 8'h00, 0, 1, 0, 0, 0);
    add(0, 8'h00, 0, 0, 0, 0, 0);
    // round-robin, FF held with ready: 0..7 then wrap to 0
    add(0, 8'hFF, 1, 1, 1, 0, 0);
    for (int k = 1; k < 8; k++) add(0, 8'hFF, 1, 1, 1, 3'(k), 3'(k));
    add(0, 8'hFF, 1, 1, 1, 0, 0);
    add(0, 8'h00, 1, 1, 0, 0, 1);
    // backpressure: 10 loaded, req moves to 01 while ready low
    add(0, 8'h10, 1, 0, 1, 4, 1);
    for (int k = 0; k < 5; k++) add(0, 8'h01, 1, 0, 1, 4, 1);
    add(0, 8'h01, 1, 1, 1, 0, 5);
    add(0, 8'h00, 1, 1, 0, 0, 1);
    // mode switch with ptr parked at 3
    add(0, 8'h04, 1, 0, 1, 2, 1);
    add(0, 8'h00, 1, 1, 0, 0, 3);
    add(0, 8'h0C, 0, 0, 1, 2, 3);
    add(0, 8'h0C, 1, 1, 1, 3, 3);
    add(0, 8'h00, 1, 1, 0, 0, 4);
    // WIDTH=5: wrap at 4, never at 7
    add(1, 8'h08, 1, 0, 1, 3, 0);
    add(1, 8'h00, 1, 1, 0, 0, 4);
    add(1, 8'h03, 1, 0, 1, 0, 4);
    add(1, 8'h03, 1, 1, 1, 1, 1);
    add(1, 8'h00, 1, 1, 0, 0, 2);
    add(1, 8'h10, 1, 0, 1, 4, 2);
    add(1, 8'h00, 1, 1, 0, 0, 0);
    add(1, 8'h00, 1, 1, 0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i]);
      exp_q.push_back(tbl[i]);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      oh_exp = 8'(1) << e.epos;
      if (e.w5) begin
        check("valid5", i, 32'(v5), 32'(e.ev));
        if (e.ev) begin
          check("pos5", i, 32'(pos5), 32'(e.epos));
          check("onehot5", i, 32'(oh5), 32'(oh_exp));
        end
        check("ptr5", i, 32'(ptr5), 32'(e.eptr));
      end else begin
        check("valid8", i, 32'(v8), 32'(e.ev));
        if (e.ev) begin
          check("pos8", i, 32'(pos8), 32'(e.epos));
          check("onehot8", i, 32'(oh8), 32'(oh_exp));
        end
        check("ptr8", i, 32'(ptr8), 32'(e.eptr));
      end
    end

    // reset asserted mid-HOLD takes effect without a clock edge
    req8 = 8'h80; mode8 = 1'b0; rdy8 = 1'b0; req5 = '0; rdy5 = 1'b0;
    @(posedge clk);
    #1;
    check("hold_valid", 100, 32'(v8), 1);
    check("hold_pos", 100, 32'(pos8), 7);
    check("hold_ptr", 100, 32'(ptr8), 4);
    #2;
    rst = 1'b0;
    #1;
    check("async_valid", 101, 32'(v8), 0);
    check("async_pos", 101, 32'(pos8), 0);
    check("async_onehot", 101, 32'(oh8), 0);
    check("async_ptr", 101, 32'(ptr8), 0);
    #1;
    req8 = '0; rdy8 = 1'b1;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("post_rst_idle", 102, 32'(v8), 0);
    check("post_rst_ptr", 102, 32'(ptr8), 0);
    req8 = 8'h60; mode8 = 1'b1; rdy8 = 1'b0;
    @(posedge clk);
    #1;
    check("post_rst_pos", 103, 32'(pos8), 5);
    check("post_rst_load", 103, 32'(v8), 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
